compare_scheduler: RTL

COMPARE_SCHEDULER -- requirements
Module: compare_scheduler

---
 rtl/compare_scheduler_if.sv | 34 +++
 rtl/compare_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/compare_scheduler_if.sv
// Bus bundle between the compare scheduler, its requesters, the shared redundant
// comparator and the response consumer.
interface compare_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        cmp_a;
    logic [7:0]        cmp_b;
    logic              cmp_eq;
    logic              cmp_error;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic              rsp_eq;
    logic              rsp_fault;
    logic [7:0]        err_count;
    logic              fault_sticky;
    logic              fault_clr;

    modport master (
        output req_valid, req_a, req_b, cmp_eq, cmp_error, rsp_ready, fault_clr,
        input  req_ready, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_eq, rsp_fault,
               err_count, fault_sticky
    );

    modport slave (
        input  req_valid, req_a, req_b, cmp_eq, cmp_error, rsp_ready, fault_clr,
        output req_ready, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_eq, rsp_fault,
               err_count, fault_sticky
    );
endinterface

// File: rtl/compare_scheduler.sv
// Round-robin scheduler sharing one redundant 8-bit comparator among NREQ
// requesters, with bounded re-sampling on copy disagreement and a sticky fault.
module compare_scheduler #(
    parameter int NREQ          = 4,
    parameter int MAX_RETRY     = 2,
    parameter int LOCK_ON_FAULT = 1
) (
    input logic clk,
    input logic rst,
    compare_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [2:0] LAST_ID   = 3'(NREQ - 1);

    state_t          state;
    logic [2:0]      rr_ptr;
    logic [2:0]      retry_cnt;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [2:0]      grant_id;
    logic [7:0]      grant_a;
    logic [7:0]      grant_b;
    logic            locked;
    logic            fault_set;

    assign locked    = (LOCK_ON_FAULT != 0) && bus.fault_sticky;
    assign fault_set = (state == CMP) && bus.cmp_error && (retry_cnt == RETRY_MAX);

    // The grant must be combinational: a registered ready could pulse for a
    // requester that has since dropped req_valid.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        grant_a   = '0;
        grant_b   = '0;
        if (state == IDLE && !rst && !locked) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_any && bus.req_valid[i] && 3'(i) >= rr_ptr) begin
                    grant_any = 1'b1;
                    grant_id  = 3'(i);
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_any && bus.req_valid[i] && 3'(i) < rr_ptr) begin
                    grant_any = 1'b1;
                    grant_id  = 3'(i);
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant_any && 3'(i) == grant_id) begin
                    grant[i] = 1'b1;
                    grant_a  = bus.req_a[8*i +: 8];
                    grant_b  = bus.req_b[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            retry_cnt        <= '0;
            bus.cmp_a        <= '0;
            bus.cmp_b        <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_eq       <= 1'b0;
            bus.rsp_fault    <= 1'b0;
            bus.err_count    <= '0;
            bus.fault_sticky <= 1'b0;
        end else begin
            if (fault_set) begin
                bus.fault_sticky <= 1'b1;
            end else if (bus.fault_clr) begin
                bus.fault_sticky <= 1'b0;
            end

            if (state == CMP && bus.cmp_error && bus.err_count != 8'hFF) begin
                bus.err_count <= bus.err_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.cmp_a  <= grant_a;
                        bus.cmp_b  <= grant_b;
                        bus.rsp_id <= grant_id;
                        retry_cnt  <= '0;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    if (!bus.cmp_error) begin
                        bus.rsp_eq    <= bus.cmp_eq;
                        bus.rsp_fault <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (retry_cnt != RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 3'd1;
                    end else begin
                        bus.rsp_eq    <= 1'b0;
                        bus.rsp_fault <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rr_ptr        <= (bus.rsp_id == LAST_ID) ? 3'd0 : bus.rsp_id + 3'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
